// File: rtl/board_mem_rmw.sv
// rtl/board_mem_rmw.sv - game-board cell memory with RMW port, sweep clear and ship counter
module board_mem_rmw #(
  parameter int X_SIZE       = 12,
  parameter int Y_SIZE       = 12,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2,
  parameter logic [DATA_WIDTH-1:0] COUNT_CODE = 2'b01,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_req,
  input  logic                                 wr_en,
  input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 wr_ack,
  output logic                                 wr_err,
  output logic                                 busy,
  input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] rd_a_addr,
  output logic [DATA_WIDTH-1:0]                rd_a_data,
  input  logic                                 rd_b_en,
  input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] rd_b_addr,
  output logic [DATA_WIDTH-1:0]                rd_b_data,
  output logic                                 rd_b_valid,
  output logic [CNT_WIDTH-1:0]                 ship_cnt
);

  localparam int AW    = X_ADDR_WIDTH + Y_ADDR_WIDTH;
  localparam int CELLS = X_SIZE * Y_SIZE;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [1:0] {CLEAR, IDLE, WR_RD, WR_UPD} state_t;

  state_t                state;
  logic [IDX_W-1:0]      sweep_idx;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] mem [CELLS];

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] rd_a_val;
  logic [DATA_WIDTH-1:0] rd_b_val;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (int'(a[AW-1:Y_ADDR_WIDTH]) < X_SIZE) && (int'(a[Y_ADDR_WIDTH-1:0]) < Y_SIZE);
  endfunction

  // x-major linear index: consecutive indices walk y first, then x
  function automatic logic [IDX_W-1:0] cell_idx(input logic [AW-1:0] a);
    return IDX_W'(int'(a[AW-1:Y_ADDR_WIDTH]) * Y_SIZE + int'(a[Y_ADDR_WIDTH-1:0]));
  endfunction

  // Select the single memory write source: sweep zeroing or the RMW commit
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = sweep_idx;
    mem_wdata = '0;
    if (rst_n) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (state == WR_UPD) begin
        mem_we    = 1'b1;
        mem_widx  = wr_idx_q;
        mem_wdata = wr_data_q;
      end
    end
  end

  // Cell storage; contents are defined by the sweep rather than by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= mem_wdata;
  end

  // Read data is forced to zero while sweeping and for addresses off the board
  always_comb begin
    rd_a_val = '0;
    rd_b_val = '0;
    if (state != CLEAR && in_range(rd_a_addr)) rd_a_val = mem[cell_idx(rd_a_addr)];
    if (state != CLEAR && in_range(rd_b_addr)) rd_b_val = mem[cell_idx(rd_b_addr)];
  end

  // Registered read ports; port B holds its data between strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_a_data  <= '0;
      rd_b_data  <= '0;
      rd_b_valid <= 1'b0;
    end else begin
      rd_a_data  <= rd_a_val;
      rd_b_valid <= rd_b_en;
      if (rd_b_en) rd_b_data <= rd_b_val;
    end
  end

  // Control FSM: sweep clear, write acceptance, read-old then commit with count update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      sweep_idx <= '0;
      busy      <= 1'b1;
      ship_cnt  <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      old_q     <= '0;
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        CLEAR: begin
          ship_cnt <= '0;
          if (wr_en) wr_err <= 1'b1;
          if (sweep_idx == IDX_W'(CELLS - 1)) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state     <= CLEAR;
            sweep_idx <= '0;
            busy      <= 1'b1;
            ship_cnt  <= '0;
            if (wr_en) wr_err <= 1'b1;
          end else if (wr_en) begin
            if (in_range(wr_addr)) begin
              wr_idx_q  <= cell_idx(wr_addr);
              wr_data_q <= wr_data;
              state     <= WR_RD;
              busy      <= 1'b1;
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        WR_RD: begin
          if (wr_en) wr_err <= 1'b1;
          old_q <= mem[wr_idx_q];
          state <= WR_UPD;
        end
        WR_UPD: begin
          if (wr_en) wr_err <= 1'b1;
          if (old_q != COUNT_CODE && wr_data_q == COUNT_CODE) ship_cnt <= ship_cnt + 1'b1;
          else if (old_q == COUNT_CODE && wr_data_q != COUNT_CODE) ship_cnt <= ship_cnt - 1'b1;
          wr_ack <= 1'b1;
          state  <= IDLE;
          busy   <= 1'b0;
        end
        default: begin
          state     <= CLEAR;
          sweep_idx <= '0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_mem_rmw.sv
// tb/tb_board_mem_rmw.sv - directed self-checking bench for board_mem_rmw
module tb_board_mem_rmw;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear_req;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [1:0] wr_data;
  logic       wr_ack;
  logic       wr_err;
  logic       busy;
  logic [7:0] rd_a_addr;
  logic [1:0] rd_a_data;
  logic       rd_b_en;
  logic [7:0] rd_b_addr;
  logic [1:0] rd_b_data;
  logic       rd_b_valid;
  logic [7:0] ship_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  board_mem_rmw dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .busy(busy),
    .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
    .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
    .rd_b_valid(rd_b_valid), .ship_cnt(ship_cnt)
  );

  function automatic logic [7:0] xy(input int x, input int y);
    return {4'(x), 4'(y)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [1:0] d,
                          output logic ack, output logic err, output int cyc);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    cyc = 1;
    while (!wr_ack && !wr_err && cyc < 8) begin
      tick();
      cyc++;
    end
    ack = wr_ack;
    err = wr_err;
  endtask

  task automatic test_reset();
    int n;
    int bad;
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (busy !== 1'b1 || ship_cnt !== 8'd0 || wr_ack !== 1'b0 || wr_err !== 1'b0 || rd_b_valid !== 1'b0 || rd_a_data !== 2'd0 || rd_b_data !== 2'd0) begin
      fails++; $display("FAIL reset_state: busy=%b cnt=%0d ack=%b err=%b bv=%b a=%0d b=%0d, required busy=1 rest 0", busy, ship_cnt, wr_ack, wr_err, rd_b_valid, rd_a_data, rd_b_data);
    end
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    tests++; if (n !== 144) begin
      fails++; $display("FAIL reset_sweep_len: got %0d cycles, required 144", n);
    end
    bad = 0;
    rd_b_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rd_a_addr = 8'(i);
      rd_b_addr = 8'(255 - i);
      tick();
      if (rd_a_data !== 2'd0 || rd_b_data !== 2'd0 || rd_b_valid !== 1'b1) bad++;
    end
    rd_b_en = 1'b0;
    tests++; if (bad !== 0) begin
      fails++; $display("FAIL reset_all_zero: %0d bad reads, required 0", bad);
    end
    tests++; if (ship_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d, required 0", ship_cnt);
    end
  endtask

  task automatic test_write_basic();
    logic ack, err;
    int   cyc;
    rd_a_addr = xy(3, 5);
    wr_en = 1'b1; wr_addr = xy(3, 5); wr_data = 2'b01;
    tick();
    wr_en = 1'b0;
    tests++; if (busy !== 1'b1 || wr_ack !== 1'b0) begin
      fails++; $display("FAIL wr_e0: busy=%b ack=%b, required 1 0", busy, wr_ack);
    end
    tick();
    tests++; if (wr_ack !== 1'b0 || ship_cnt !== 8'd0) begin
      fails++; $display("FAIL wr_e1: ack=%b cnt=%0d, required 0 0", wr_ack, ship_cnt);
    end
    tick();
    tests++; if (wr_ack !== 1'b1 || ship_cnt !== 8'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL wr_e2: ack=%b cnt=%0d busy=%b, required 1 1 0", wr_ack, ship_cnt, busy);
    end
    tests++; if (rd_a_data !== 2'b00) begin
      fails++; $display("FAIL rd_at_e2_old: got %0d, required 0", rd_a_data);
    end
    tick();
    tests++; if (rd_a_data !== 2'b01 || wr_ack !== 1'b0) begin
      fails++; $display("FAIL rd_after_e2: data=%0d ack=%b, required 1 0", rd_a_data, wr_ack);
    end
    do_write(xy(3, 5), 2'b10, ack, err, cyc);
    tests++; if (ack !== 1'b1 || err !== 1'b0 || cyc !== 3 || ship_cnt !== 8'd0) begin
      fails++; $display("FAIL overwrite: ack=%b err=%b cyc=%0d cnt=%0d, required 1 0 3 0", ack, err, cyc, ship_cnt);
    end
  endtask

  task automatic test_range();
    logic ack, err;
    int   cyc;
    do_write(xy(12, 0), 2'b01, ack, err, cyc);
    tests++; if (err !== 1'b1 || ack !== 1'b0 || cyc !== 1 || ship_cnt !== 8'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL range_x: err=%b ack=%b cyc=%0d cnt=%0d busy=%b, required 1 0 1 0 0", err, ack, cyc, ship_cnt, busy);
    end
    do_write(xy(0, 15), 2'b01, ack, err, cyc);
    tests++; if (err !== 1'b1 || ack !== 1'b0 || cyc !== 1 || ship_cnt !== 8'd0) begin
      fails++; $display("FAIL range_y: err=%b ack=%b cyc=%0d cnt=%0d, required 1 0 1 0", err, ack, cyc, ship_cnt);
    end
    rd_b_en = 1'b1; rd_b_addr = xy(3, 5);
    tick();
    tests++; if (rd_b_data !== 2'b10 || rd_b_valid !== 1'b1) begin
      fails++; $display("FAIL rdb_read: data=%0d valid=%b, required 2 1", rd_b_data, rd_b_valid);
    end
    rd_b_en = 1'b0; rd_b_addr = xy(12, 0);
    tick();
    tests++; if (rd_b_data !== 2'b10 || rd_b_valid !== 1'b0) begin
      fails++; $display("FAIL rdb_hold: data=%0d valid=%b, required 2 0", rd_b_data, rd_b_valid);
    end
    rd_b_en = 1'b1; rd_a_addr = xy(0, 15);
    tick();
    rd_b_en = 1'b0;
    tests++; if (rd_b_data !== 2'b00 || rd_b_valid !== 1'b1 || rd_a_data !== 2'b00) begin
      fails++; $display("FAIL rd_oor: b=%0d valid=%b a=%0d, required 0 1 0", rd_b_data, rd_b_valid, rd_a_data);
    end
  endtask

  task automatic test_back_to_back();
    logic ack, err;
    int   cyc;
    wr_en = 1'b1; wr_addr = xy(1, 1); wr_data = 2'b01;
    tick();
    wr_addr = xy(2, 2);
    tick();
    wr_en = 1'b0;
    tests++; if (wr_err !== 1'b1) begin
      fails++; $display("FAIL b2b_reject: err=%b, required 1", wr_err);
    end
    tick();
    tests++; if (wr_ack !== 1'b1 || wr_err !== 1'b0 || ship_cnt !== 8'd1) begin
      fails++; $display("FAIL b2b_first_ack: ack=%b err=%b cnt=%0d, required 1 0 1", wr_ack, wr_err, ship_cnt);
    end
    rd_a_addr = xy(2, 2);
    tick();
    tests++; if (rd_a_data !== 2'b00) begin
      fails++; $display("FAIL b2b_untouched: got %0d, required 0", rd_a_data);
    end
    do_write(xy(1, 1), 2'b01, ack, err, cyc);
    tests++; if (ack !== 1'b1 || ship_cnt !== 8'd1) begin
      fails++; $display("FAIL same_value: ack=%b cnt=%0d, required 1 1", ack, ship_cnt);
    end
  endtask

  task automatic test_clear();
    logic ack, err;
    int   cyc;
    int   n;
    int   bad;
    do_write(xy(4, 0), 2'b01, ack, err, cyc);
    do_write(xy(5, 11), 2'b01, ack, err, cyc);
    do_write(xy(11, 11), 2'b01, ack, err, cyc);
    do_write(xy(0, 0), 2'b01, ack, err, cyc);
    tests++; if (ship_cnt !== 8'd5) begin
      fails++; $display("FAIL fill5: got %0d, required 5", ship_cnt);
    end
    rd_a_addr = xy(11, 11);
    clear_req = 1'b1; wr_en = 1'b1; wr_addr = xy(6, 6); wr_data = 2'b01;
    tick();
    clear_req = 1'b0; wr_en = 1'b0;
    tests++; if (wr_err !== 1'b1 || busy !== 1'b1 || ship_cnt !== 8'd0 || wr_ack !== 1'b0) begin
      fails++; $display("FAIL clear_start: err=%b busy=%b cnt=%0d ack=%b, required 1 1 0 0", wr_err, busy, ship_cnt, wr_ack);
    end
    n = 0;
    while (busy && n < 300) begin
      clear_req = (n == 10);
      tick();
      n++;
      if (n == 5) begin
        tests++; if (rd_a_data !== 2'b00) begin
          fails++; $display("FAIL read_in_clear: got %0d, required 0", rd_a_data);
        end
      end
    end
    clear_req = 1'b0;
    tests++; if (n !== 144 || ship_cnt !== 8'd0) begin
      fails++; $display("FAIL clear_sweep: %0d cycles cnt=%0d, required 144 0", n, ship_cnt);
    end
    bad = 0;
    rd_b_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rd_a_addr = 8'(i);
      rd_b_addr = 8'(i);
      tick();
      if (rd_a_data !== 2'd0 || rd_b_data !== 2'd0) bad++;
    end
    rd_b_en = 1'b0;
    tests++; if (bad !== 0) begin
      fails++; $display("FAIL clear_all_zero: %0d bad reads, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_write();
    logic ack, err;
    int   cyc;
    int   n;
    int   acks;
    do_write(xy(7, 7), 2'b01, ack, err, cyc);
    tests++; if (ack !== 1'b1 || ship_cnt !== 8'd1) begin
      fails++; $display("FAIL pre_write: ack=%b cnt=%0d, required 1 1", ack, ship_cnt);
    end
    wr_en = 1'b1; wr_addr = xy(7, 7); wr_data = 2'b11;
    tick();
    wr_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++; if (busy !== 1'b1 || wr_ack !== 1'b0 || ship_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_mid: busy=%b ack=%b cnt=%0d, required 1 0 0", busy, wr_ack, ship_cnt);
    end
    n = 0;
    acks = 0;
    while (busy && n < 300) begin
      tick();
      n++;
      if (wr_ack) acks++;
    end
    tests++; if (n !== 144 || acks !== 0) begin
      fails++; $display("FAIL reset_mid_sweep: %0d cycles %0d acks, required 144 0", n, acks);
    end
    rd_a_addr = xy(7, 7); rd_b_addr = xy(7, 7); rd_b_en = 1'b1;
    tick();
    rd_b_en = 1'b0;
    tests++; if (rd_a_data !== 2'b00 || rd_b_data !== 2'b00 || ship_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_mid_cell: a=%0d b=%0d cnt=%0d, required 0 0 0", rd_a_data, rd_b_data, ship_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_a_addr = '0; rd_b_en = 1'b0; rd_b_addr = '0;
    @(negedge clk);
    test_reset();
    test_write_basic();
    test_range();
    test_back_to_back();
    test_clear();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_mem_rmw.md
Name: board_mem_rmw

Overview:
Single-clock successor to the game-board memory. Holds an X_SIZE x Y_SIZE array of DATA_WIDTH-bit cell codes and provides:
- two independent registered read ports: A for the display path, B for game logic with a valid strobe;
- a handshaked read-modify-write port with range checking;
- a self-clearing sweep engine run on reset and on request;
- a live count of cells holding COUNT_CODE (remaining ship cells), used by the game FSM to detect defeat.

Parameters:
X_SIZE, 12, board width in cells
Y_SIZE, 12, board height in cells
X_ADDR_WIDTH, 4, x field width of address
Y_ADDR_WIDTH, 4, y field width of address
DATA_WIDTH, 2, cell code width
COUNT_CODE, 2'b01, cell code tallied by ship_cnt
CNT_WIDTH, 8, ship_cnt width; must satisfy 2**CNT_WIDTH > X_SIZE*Y_SIZE

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  synchronous active-low reset
clear_req  in  1  one-cycle request to zero the whole board
wr_en  in  1  write request, sampled each clk edge
wr_addr  in  X_ADDR_WIDTH+Y_ADDR_WIDTH  {x, y}: x in upper field, y in lower field
wr_data  in  DATA_WIDTH  new cell code
wr_ack  out  1  one-cycle pulse: write committed
wr_err  out  1  one-cycle pulse: write rejected
busy  out  1  high while clearing or a write is in flight
rd_a_addr  in  X_ADDR_WIDTH+Y_ADDR_WIDTH  read port A address {x, y}
rd_a_data  out  DATA_WIDTH  port A data, 1-cycle latency, reads every cycle
rd_b_en  in  1  port B read strobe
rd_b_addr  in  X_ADDR_WIDTH+Y_ADDR_WIDTH  read port B address {x, y}
rd_b_data  out  DATA_WIDTH  port B data, held between reads
rd_b_valid  out  1  one-cycle pulse, 1 cycle after rd_b_en
ship_cnt  out  CNT_WIDTH  number of cells equal to COUNT_CODE

Behaviour:
- Reset (rst_n low at an edge):
  - state=CLEAR, sweep index=0, busy=1, ship_cnt=0.
  - wr_ack=0, wr_err=0, rd_a_data=0, rd_b_data=0, rd_b_valid=0.
  - Reset mid-write or mid-clear aborts that operation and restarts the sweep from index 0.
- States: CLEAR, IDLE, WR_RD, WR_UPD.
- CLEAR:
  - Writes 0 to one cell per cycle in x-major order (x=0,y=0..Y_SIZE-1, then x=1, ...).
  - Takes exactly X_SIZE*Y_SIZE cycles, then enters IDLE; busy falls on the same edge.
  - ship_cnt is held at 0 throughout.
  - Both read ports return 0 while in CLEAR.
- IDLE, clear_req=1:
  - Enters CLEAR with index 0 and ship_cnt=0.
  - If wr_en is also high, clear wins: wr_err pulses and the write is dropped.
- IDLE, wr_en=1, address in range (x<X_SIZE and y<Y_SIZE):
  - Edge E0: latch addr/data, go to WR_RD, busy=1.
  - Edge E1: capture old cell value, go to WR_UPD.
  - Edge E2: write cell, update ship_cnt, wr_ack=1 for one cycle, go to IDLE, busy=0.
  - A new write is accepted at E2+1.
- IDLE, wr_en=1, address out of range: wr_err=1 for one cycle after the edge, no state change, memory untouched.
- wr_en while busy: rejected, wr_err pulses, memory untouched.
- clear_req while busy: ignored, not queued.
- Count update at E2:
  - old!=COUNT_CODE and new==COUNT_CODE: +1.
  - old==COUNT_CODE and new!=COUNT_CODE: -1.
  - Otherwise unchanged, including rewriting the same value.
- Read ports:
  - Registered, 1-cycle latency; read-only, no side effects.
  - Out-of-range address returns 0.
  - A read of the cell being written returns the old value up to and including the read issued at E2; reads issued after E2 return the new value.
  - rd_b_data holds its last value when rd_b_en is low.
  - Both ports may address the same cell in the same cycle.
- Storage: implementation may replicate the array per read port to meet port count. All replicas are updated identically; no behavioural difference is permitted.

Test Plan:
- Reset release -> busy high for exactly 144 cycles (12x12), then 0; every cell reads 0 on both ports; ship_cnt=0.
- Write 2'b01 at {4'd3,4'd5} -> wr_ack pulse 2 cycles after acceptance; ship_cnt 0->1 on the same edge; port A reads 2'b01 after that edge. Then overwrite it with 2'b10 -> ship_cnt back to 0.
- Write to {4'd12,4'd0} and {4'd0,4'd15} -> wr_err pulse each, no wr_ack, ship_cnt unchanged; reads of those addresses return 0.
- Issue wr_en on the cycle after an accepted write -> wr_err pulse, first write still acks; rewrite 2'b01 over 2'b01 -> ship_cnt unchanged.
- Fill 5 ship cells (ship_cnt=5), then clear_req together with wr_en -> wr_err pulse, 144-cycle sweep, ship_cnt=0, all reads 0.
- Assert rst_n low at E1 of an in-flight write -> no wr_ack; sweep restarts at index 0; after 144 cycles the target cell is 0.
